vcmp_sequencer: RTL and testbench
=================================

// Module: vcmp_sequencer
// PURPOSE
// - Sequences one vector compare instruction through the single shared, clock-gated COM comparator, one element per cycle.
// - Accepts a packed request (valid/ready), drives the comparator's en/a/b/leq/tc inputs, and samples lt_le/ge_gt.
// - Builds the destination mask with RVV-style mask-undisturbed and tail-undisturbed rules, then returns it (valid/ready).
// - Sits between the vector issue stage and the COM instance inside the ALU.
// PARAMETERS
// - DATA_WIDTH  32  element width; must match COM.DATA_WIDTH
// - NUM_ELEM    8   elements per vector register (max vl)
// - VL_W        $clog2(NUM_ELEM+1)  vl field width (localparam)
// PORTS
// - module_clk_i   in   1                    clock
// - rst_ni         in   1                    async active-low reset
// - req_valid_i    in   1                    request valid
// - req_ready_o    out  1                    request ready (state IDLE)
// - req_op_i       in   2                    00 LT, 01 LE, 10 GT, 11 GE
// - req_tc_i       in   1                    1 = signed (two's complement)
// - req_vx_i       in   1                    1 = b is req_scalar_i broadcast
// - req_vl_i       in   VL_W                 active vector length
// - req_vm_i       in   1                    1 = unmasked; 0 = use req_mask_i
// - req_a_i        in   NUM_ELEM*DATA_WIDTH  vs2 operand, element k at [k*DW +: DW]
// - req_b_i        in   NUM_ELEM*DATA_WIDTH  vs1 operand
// - req_scalar_i   in   DATA_WIDTH           rs1 operand
// - req_mask_i     in   NUM_ELEM             v0 mask
// - req_old_i      in   NUM_ELEM             old destination mask
// - kill_i         in   1                    abort current instruction
// - cmp_en_o       out  1                    COM en_i (clock gate)
// - cmp_a_o        out  DATA_WIDTH           COM a_i
// - cmp_b_o        out  DATA_WIDTH           COM b_i
// - cmp_leq_o      out  1                    COM leq_i
// - cmp_tc_o       out  1                    COM tc_i
// - cmp_lt_le_i    in   1                    COM lt_le_o
// - cmp_ge_gt_i    in   1                    COM ge_gt_o
// - res_valid_o    out  1                    result valid (state DONE)
// - res_ready_i    in   1                    result consumed
// - res_mask_o     out  NUM_ELEM             destination mask
// - busy_o         out  1                    state != IDLE
// BEHAVIOUR
// - One clock, module_clk_i. Reset is asynchronous, active-low (rst_ni). In reset: state=IDLE, idx=0, all operand/result registers=0, every output 0 except req_ready_o=1.
// - FSM IDLE->RUN on req_valid_i&&req_ready_o. All req_* fields latch on that edge; vl is clamped to NUM_ELEM.
// - If the latched vl==0: IDLE->DONE directly, res_mask=old.
// - RUN: request accepted at edge T; element k is compared in cycle T+1+k. After element vl-1, go to DONE.
//   - res_valid_o rises in cycle T+vl+1; latency is vl+1 cycles.
// - DONE: res_valid_o=1 and res_mask_o is stable until res_ready_i; then DONE->IDLE.
//   - A new request can be accepted in the cycle after the result handshake; there is no back-to-back overlap.
// - COM is combinational, so each element's result bit is sampled at the end of its RUN cycle.
// - Op mapping:
//   - LT: leq=0, bit=lt_le
//   - GE: leq=0, bit=ge_gt
//   - LE: leq=1, bit=lt_le
//   - GT: leq=1, bit=ge_gt
// - cmp_tc_o = latched tc. cmp_a_o = a[idx]; cmp_b_o = vx ? scalar : b[idx].
// - cmp_en_o=1 only in RUN cycles whose element is active (vm=1 or mask[idx]=1).
// - Outside RUN: cmp_a_o, cmp_b_o, cmp_leq_o and cmp_tc_o are held at 0, so the comparator inputs do not toggle.
// - Masked-off element (vm=0, mask[k]=0): bit k = old[k]; the element still takes its cycle.
// - Tail element (k>=vl): bit k = old[k]. The result register is preloaded with old at accept.
// - kill_i in RUN or DONE: go to IDLE at the next edge, with no res_valid_o. kill_i beats a same-cycle res_ready_i.
// - kill_i in IDLE is ignored, and the request may still be accepted that cycle.
// - rst_ni asserted mid-operation: immediate return to reset values; no partial result is ever presented.
// - idx width is VL_W; idx never wraps, because RUN exits at vl-1.
// STRUCTURE
// - vcmp_pkg holds:
//   - cmp_op_e {CMP_LT, CMP_LE, CMP_GT, CMP_GE}
//   - vcmp_state_e {IDLE, RUN, DONE}
//   - the functions op_to_leq(op) and op_sel_ge(op)
// - One sub-module, vcmp_elem_sel: a combinational slice mux (a, b, scalar, vx, idx -> cmp_a, cmp_b).
// - COM is instantiated by the parent, not inside this block.
// TESTING (NUM_ELEM=8, DATA_WIDTH=32, COM in the bench)
// - a=elements 0..7, vx=1, scalar=4, LT, tc=0, vl=8, vm=1, old=0 -> res_mask=8'h0F; res_valid_o 9 cycles after accept.
// - a[0]=32'hFFFF_FFFF, b[0]=1, LT, vl=1: tc=1 -> bit0=1; tc=0 -> bit0=0. GE on the same operands gives the inverse.
// - All elements true, vm=0, mask=8'hAA, old=8'h00 -> res_mask=8'hAA; cmp_en_o high in exactly 4 of 8 RUN cycles.
// - vl=0, old=8'h5C -> res_valid_o the cycle after accept, mask 8'h5C. vl=3, all true, old=8'hF0 -> 8'hF7.
// - res_ready_i low for 5 cycles: res_mask_o stable, req_ready_o=0; a new request is accepted 1 cycle after the handshake.
// - kill_i in the RUN cycle of idx 3 -> IDLE next cycle, no res_valid_o. rst_ni pulse mid-RUN -> all outputs reset, req_ready_o=1.

Source files
------------

// File: rtl/vcmp_pkg.sv
// Shared types and op-decoding helpers for the vector compare sequencer.
package vcmp_pkg;

    typedef enum logic [1:0] {
        CMP_LT = 2'b00,
        CMP_LE = 2'b01,
        CMP_GT = 2'b10,
        CMP_GE = 2'b11
    } cmp_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } vcmp_state_e;

    // LE and GT both use the comparator's "or-equal" mode.
    function automatic logic op_to_leq(cmp_op_e op);
        return (op == CMP_LE) || (op == CMP_GT);
    endfunction

    // GT and GE take the comparator's ge_gt output, LT and LE take lt_le.
    function automatic logic op_sel_ge(cmp_op_e op);
        return (op == CMP_GT) || (op == CMP_GE);
    endfunction

endpackage

// File: rtl/vcmp_sequencer_if.sv
// Bundles the issue-side request/result handshake and the COM comparator port.
interface vcmp_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ELEM   = 8
);
    localparam int VL_W = $clog2(NUM_ELEM + 1);

    logic                           req_valid_i;
    logic                           req_ready_o;
    logic [1:0]                     req_op_i;
    logic                           req_tc_i;
    logic                           req_vx_i;
    logic [VL_W-1:0]                req_vl_i;
    logic                           req_vm_i;
    logic [NUM_ELEM*DATA_WIDTH-1:0] req_a_i;
    logic [NUM_ELEM*DATA_WIDTH-1:0] req_b_i;
    logic [DATA_WIDTH-1:0]          req_scalar_i;
    logic [NUM_ELEM-1:0]            req_mask_i;
    logic [NUM_ELEM-1:0]            req_old_i;
    logic                           kill_i;
    logic                           cmp_en_o;
    logic [DATA_WIDTH-1:0]          cmp_a_o;
    logic [DATA_WIDTH-1:0]          cmp_b_o;
    logic                           cmp_leq_o;
    logic                           cmp_tc_o;
    logic                           cmp_lt_le_i;
    logic                           cmp_ge_gt_i;
    logic                           res_valid_o;
    logic                           res_ready_i;
    logic [NUM_ELEM-1:0]            res_mask_o;
    logic                           busy_o;

    // Issue stage / ALU side: drives requests and comparator results.
    modport master (
        output req_valid_i, req_op_i, req_tc_i, req_vx_i, req_vl_i, req_vm_i,
               req_a_i, req_b_i, req_scalar_i, req_mask_i, req_old_i, kill_i,
               cmp_lt_le_i, cmp_ge_gt_i, res_ready_i,
        input  req_ready_o, cmp_en_o, cmp_a_o, cmp_b_o, cmp_leq_o, cmp_tc_o,
               res_valid_o, res_mask_o, busy_o
    );

    // Sequencer side.
    modport slave (
        input  req_valid_i, req_op_i, req_tc_i, req_vx_i, req_vl_i, req_vm_i,
               req_a_i, req_b_i, req_scalar_i, req_mask_i, req_old_i, kill_i,
               cmp_lt_le_i, cmp_ge_gt_i, res_ready_i,
        output req_ready_o, cmp_en_o, cmp_a_o, cmp_b_o, cmp_leq_o, cmp_tc_o,
               res_valid_o, res_mask_o, busy_o
    );

endinterface

// File: rtl/vcmp_elem_sel.sv
// Picks the current element of a and b (or the broadcast scalar) for the comparator.
module vcmp_elem_sel #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ELEM   = 8,
    parameter int IDX_W      = 3
) (
    input  logic [NUM_ELEM*DATA_WIDTH-1:0] a_i,
    input  logic [NUM_ELEM*DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0]          scalar_i,
    input  logic                           vx_i,
    input  logic [IDX_W-1:0]               idx_i,
    output logic [DATA_WIDTH-1:0]          cmp_a_o,
    output logic [DATA_WIDTH-1:0]          cmp_b_o
);
    logic [DATA_WIDTH-1:0] a_arr [NUM_ELEM];
    logic [DATA_WIDTH-1:0] b_arr [NUM_ELEM];

    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_slice
        assign a_arr[k] = a_i[k*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[k] = b_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Element mux; vx replaces the vs1 element with the rs1 scalar.
    always_comb begin
        cmp_a_o = a_arr[idx_i];
        cmp_b_o = vx_i ? scalar_i : b_arr[idx_i];
    end

endmodule

// File: rtl/vcmp_sequencer.sv
// Steps one vector compare through the shared COM comparator, one element per
// cycle, and assembles a mask/tail-undisturbed destination mask.
module vcmp_sequencer
    import vcmp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ELEM   = 8
) (
    input  logic            module_clk_i,
    input  logic            rst_ni,
    vcmp_sequencer_if.slave bus
);
    localparam int              VL_W   = $clog2(NUM_ELEM + 1);
    localparam int              IDX_W  = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam logic [VL_W-1:0] MAX_VL = VL_W'(NUM_ELEM);
    localparam logic [VL_W-1:0] VL_ONE = VL_W'(1);

    vcmp_state_e                    state_q, state_d;
    logic [VL_W-1:0]                idx_q, idx_d;
    logic [VL_W-1:0]                vl_q, vl_d;
    cmp_op_e                        op_q, op_d;
    logic                           tc_q, tc_d;
    logic                           vx_q, vx_d;
    logic                           vm_q, vm_d;
    logic [NUM_ELEM*DATA_WIDTH-1:0] a_q, a_d;
    logic [NUM_ELEM*DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0]          scalar_q, scalar_d;
    logic [NUM_ELEM-1:0]            mask_q, mask_d;
    logic [NUM_ELEM-1:0]            res_q, res_d;

    logic [IDX_W-1:0]               idx_sel;
    logic [VL_W-1:0]                vl_clamped;
    logic                           elem_active;
    logic                           elem_bit;
    logic                           in_run;
    logic [DATA_WIDTH-1:0]          sel_a;
    logic [DATA_WIDTH-1:0]          sel_b;

    vcmp_elem_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_ELEM   (NUM_ELEM),
        .IDX_W      (IDX_W)
    ) u_elem_sel (
        .a_i      (a_q),
        .b_i      (b_q),
        .scalar_i (scalar_q),
        .vx_i     (vx_q),
        .idx_i    (idx_sel),
        .cmp_a_o  (sel_a),
        .cmp_b_o  (sel_b)
    );

    // Per-element decode: activity under the v0 mask and which COM output to keep.
    always_comb begin
        idx_sel     = idx_q[IDX_W-1:0];
        vl_clamped  = (bus.req_vl_i > MAX_VL) ? MAX_VL : bus.req_vl_i;
        elem_active = vm_q | mask_q[idx_sel];
        elem_bit    = op_sel_ge(op_q) ? bus.cmp_ge_gt_i : bus.cmp_lt_le_i;
        in_run      = (state_q == RUN);
    end

    // Next-state and datapath: latch on accept, fold in one result bit per RUN cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vl_d     = vl_q;
        op_d     = op_q;
        tc_d     = tc_q;
        vx_d     = vx_q;
        vm_d     = vm_q;
        a_d      = a_q;
        b_d      = b_q;
        scalar_d = scalar_q;
        mask_d   = mask_q;
        res_d    = res_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    op_d     = cmp_op_e'(bus.req_op_i);
                    tc_d     = bus.req_tc_i;
                    vx_d     = bus.req_vx_i;
                    vm_d     = bus.req_vm_i;
                    vl_d     = vl_clamped;
                    a_d      = bus.req_a_i;
                    b_d      = bus.req_b_i;
                    scalar_d = bus.req_scalar_i;
                    mask_d   = bus.req_mask_i;
                    res_d    = bus.req_old_i;
                    idx_d    = '0;
                    state_d  = (vl_clamped == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.kill_i) begin
                    state_d = IDLE;
                end else begin
                    if (elem_active) begin
                        res_d[idx_sel] = elem_bit;
                    end
                    if (idx_q == vl_q - VL_ONE) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + VL_ONE;
                    end
                end
            end
            DONE: begin
                if (bus.kill_i || bus.res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge module_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched operands, element index and the result being built.
    always_ff @(posedge module_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q    <= '0;
            vl_q     <= '0;
            op_q     <= CMP_LT;
            tc_q     <= 1'b0;
            vx_q     <= 1'b0;
            vm_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            scalar_q <= '0;
            mask_q   <= '0;
            res_q    <= '0;
        end else begin
            idx_q    <= idx_d;
            vl_q     <= vl_d;
            op_q     <= op_d;
            tc_q     <= tc_d;
            vx_q     <= vx_d;
            vm_q     <= vm_d;
            a_q      <= a_d;
            b_q      <= b_d;
            scalar_q <= scalar_d;
            mask_q   <= mask_d;
            res_q    <= res_d;
        end
    end

    // Outputs; comparator inputs are parked at zero outside RUN so COM stays quiet.
    always_comb begin
        bus.req_ready_o = (state_q == IDLE);
        bus.busy_o      = (state_q != IDLE);
        bus.res_valid_o = (state_q == DONE);
        bus.res_mask_o  = (state_q == DONE) ? res_q : '0;
        bus.cmp_en_o    = in_run & elem_active;
        bus.cmp_a_o     = in_run ? sel_a : '0;
        bus.cmp_b_o     = in_run ? sel_b : '0;
        bus.cmp_leq_o   = in_run & op_to_leq(op_q);
        bus.cmp_tc_o    = in_run & tc_q;
    end

endmodule

// File: tb/tb_vcmp_sequencer.sv
// Self-checking bench for vcmp_sequencer with a behavioural COM and a
// transaction-level reference model of the compare instruction.
module tb_vcmp_sequencer;
    localparam int DW = 32;
    localparam int NE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    vcmp_sequencer_if #(.DATA_WIDTH(DW), .NUM_ELEM(NE)) bus ();

    vcmp_sequencer #(.DATA_WIDTH(DW), .NUM_ELEM(NE)) dut (
        .module_clk_i (clk),
        .rst_ni       (rst_n),
        .bus          (bus)
    );

    // Behavioural COM: outputs forced low while gated off.
    logic com_lt, com_eq;
    always_comb begin
        com_lt = bus.cmp_tc_o ? ($signed(bus.cmp_a_o) < $signed(bus.cmp_b_o))
                              : (bus.cmp_a_o < bus.cmp_b_o);
        com_eq = (bus.cmp_a_o == bus.cmp_b_o);
        bus.cmp_lt_le_i = 1'b0;
        bus.cmp_ge_gt_i = 1'b0;
        if (bus.cmp_en_o) begin
            bus.cmp_lt_le_i = bus.cmp_leq_o ? (com_lt | com_eq) : com_lt;
            bus.cmp_ge_gt_i = bus.cmp_leq_o ? !(com_lt | com_eq) : !com_lt;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Architectural meaning of each compare op.
    function automatic logic spec_cmp(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                      input logic [1:0] op, input logic tc);
        logic lt, eq;
        lt = tc ? ($signed(a) < $signed(b)) : (a < b);
        eq = (a == b);
        case (op)
            2'd0:    return lt;
            2'd1:    return lt | eq;
            2'd2:    return !(lt | eq);
            default: return !lt;
        endcase
    endfunction

    function automatic int clamp_vl(input logic [3:0] vl);
        return (int'(vl) > NE) ? NE : int'(vl);
    endfunction

    function automatic logic [NE-1:0] model_mask(
        input logic [NE*DW-1:0] a, input logic [NE*DW-1:0] b, input logic [DW-1:0] scalar,
        input logic [1:0] op, input logic tc, input logic vx, input logic [3:0] vl,
        input logic vm, input logic [NE-1:0] mask, input logic [NE-1:0] old);
        logic [NE-1:0] r;
        int vle;
        vle = clamp_vl(vl);
        for (int k = 0; k < NE; k++) begin
            if (k < vle && (vm || mask[k]))
                r[k] = spec_cmp(a[k*DW +: DW], vx ? scalar : b[k*DW +: DW], op, tc);
            else
                r[k] = old[k];
        end
        return r;
    endfunction

    // Monitor state: the transaction in flight and how many cycles since accept.
    logic            m_active = 1'b0;
    int              m_cyc, m_vl;
    logic [NE*DW-1:0] m_a, m_b;
    logic [DW-1:0]   m_scalar;
    logic [1:0]      m_op;
    logic            m_tc, m_vx, m_vm;
    logic [NE-1:0]   m_mask, m_exp;

    // Compare process: checks every output on every cycle against the model.
    always @(negedge clk) begin
        int   k;
        logic act;
        if (!rst_n) begin
            checkOutput("rst_req_ready", bus.req_ready_o, 1);
            checkOutput("rst_busy", bus.busy_o, 0);
            checkOutput("rst_res_valid", bus.res_valid_o, 0);
            checkOutput("rst_res_mask", bus.res_mask_o, 0);
            checkOutput("rst_cmp_en", bus.cmp_en_o, 0);
            checkOutput("rst_cmp_a", bus.cmp_a_o, 0);
            checkOutput("rst_cmp_b", bus.cmp_b_o, 0);
            checkOutput("rst_cmp_leq", bus.cmp_leq_o, 0);
            checkOutput("rst_cmp_tc", bus.cmp_tc_o, 0);
            m_active = 1'b0;
        end else if (m_active) begin
            m_cyc++;
            checkOutput("busy", bus.busy_o, 1);
            checkOutput("req_ready_busy", bus.req_ready_o, 0);
            if (m_cyc <= m_vl) begin
                k   = m_cyc - 1;
                act = m_vm || m_mask[k];
                checkOutput("run_res_valid", bus.res_valid_o, 0);
                checkOutput("cmp_en", bus.cmp_en_o, act);
                checkOutput("cmp_a", bus.cmp_a_o, m_a[k*DW +: DW]);
                checkOutput("cmp_b", bus.cmp_b_o, m_vx ? m_scalar : m_b[k*DW +: DW]);
                checkOutput("cmp_leq", bus.cmp_leq_o, (m_op == 2'd1) || (m_op == 2'd2));
                checkOutput("cmp_tc", bus.cmp_tc_o, m_tc);
            end else begin
                checkOutput("done_res_valid", bus.res_valid_o, 1);
                checkOutput("res_mask", bus.res_mask_o, m_exp);
                checkOutput("done_cmp_en", bus.cmp_en_o, 0);
                checkOutput("done_cmp_a", bus.cmp_a_o, 0);
                checkOutput("done_cmp_b", bus.cmp_b_o, 0);
                if (bus.res_ready_i) m_active = 1'b0;
            end
            if (bus.kill_i) m_active = 1'b0;
        end else begin
            checkOutput("idle_req_ready", bus.req_ready_o, 1);
            checkOutput("idle_busy", bus.busy_o, 0);
            checkOutput("idle_res_valid", bus.res_valid_o, 0);
            checkOutput("idle_cmp_en", bus.cmp_en_o, 0);
            checkOutput("idle_cmp_a", bus.cmp_a_o, 0);
            checkOutput("idle_cmp_b", bus.cmp_b_o, 0);
            checkOutput("idle_cmp_leq", bus.cmp_leq_o, 0);
            checkOutput("idle_cmp_tc", bus.cmp_tc_o, 0);
            if (bus.req_valid_i) begin
                m_active = 1'b1;
                m_cyc    = 0;
                m_vl     = clamp_vl(bus.req_vl_i);
                m_a      = bus.req_a_i;
                m_b      = bus.req_b_i;
                m_scalar = bus.req_scalar_i;
                m_op     = bus.req_op_i;
                m_tc     = bus.req_tc_i;
                m_vx     = bus.req_vx_i;
                m_vm     = bus.req_vm_i;
                m_mask   = bus.req_mask_i;
                m_exp    = model_mask(bus.req_a_i, bus.req_b_i, bus.req_scalar_i, bus.req_op_i,
                                      bus.req_tc_i, bus.req_vx_i, bus.req_vl_i, bus.req_vm_i,
                                      bus.req_mask_i, bus.req_old_i);
            end
        end
    end

    // Presents a request and returns once it is accepted (just after the accept edge).
    task automatic applyStimulus(input logic [1:0] op, input logic tc, input logic vx,
                                 input logic [3:0] vl, input logic vm,
                                 input logic [NE*DW-1:0] a, input logic [NE*DW-1:0] b,
                                 input logic [DW-1:0] scalar, input logic [NE-1:0] mask,
                                 input logic [NE-1:0] old, output int waited);
        bus.req_op_i     = op;
        bus.req_tc_i     = tc;
        bus.req_vx_i     = vx;
        bus.req_vl_i     = vl;
        bus.req_vm_i     = vm;
        bus.req_a_i      = a;
        bus.req_b_i      = b;
        bus.req_scalar_i = scalar;
        bus.req_mask_i   = mask;
        bus.req_old_i    = old;
        bus.req_valid_i  = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.req_ready_o && waited < 50);
        if (!bus.req_ready_o) checkOutput("accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
    endtask

    // Waits for the result, checks it while held, then completes the handshake.
    task automatic waitResult(input int hold, input logic [NE-1:0] exp,
                              output int lat, output int en_cnt);
        lat = 0;
        en_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.cmp_en_o) en_cnt++;
        end while (!bus.res_valid_o && lat < 40);
        if (!bus.res_valid_o) checkOutput("result_timeout", 0, 1);
        checkOutput("result_mask", bus.res_mask_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_mask", bus.res_mask_o, exp);
            checkOutput("hold_valid", bus.res_valid_o, 1);
            checkOutput("hold_req_ready", bus.req_ready_o, 0);
        end
        @(posedge clk);
        #1 bus.res_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.res_ready_i = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_elem();
        logic [DW-1:0] v;
        v = $urandom;
        if ($urandom_range(0, 1) == 1)
            v = DW'($urandom_range(0, 3)) | (($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0);
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [NE*DW-1:0] a, b, all_lo, all_hi, zero;
        logic [NE-1:0]    exp;
        int               waited, lat, en_cnt, vle, r;
        logic [1:0]       op;
        logic             tc, vx, vm;
        logic [3:0]       vl;
        logic [DW-1:0]    scalar;
        logic [NE-1:0]    mask, old;

        bus.req_valid_i = 0; bus.req_op_i = 0; bus.req_tc_i = 0; bus.req_vx_i = 0;
        bus.req_vl_i = 0; bus.req_vm_i = 0; bus.req_a_i = '0; bus.req_b_i = '0;
        bus.req_scalar_i = 0; bus.req_mask_i = 0; bus.req_old_i = 0;
        bus.kill_i = 0; bus.res_ready_i = 0;
        zero = '0;
        for (int k = 0; k < NE; k++) begin
            all_lo[k*DW +: DW] = 32'd0;
            all_hi[k*DW +: DW] = 32'd1;
        end

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("reset_req_ready", bus.req_ready_o, 1);
        checkOutput("reset_res_valid", bus.res_valid_o, 0);

        $display("[TB] a=0..7 LT scalar 4");
        for (int k = 0; k < NE; k++) a[k*DW +: DW] = DW'(k);
        applyStimulus(2'd0, 0, 1, 4'd8, 1, a, zero, 32'd4, 8'h00, 8'h00, waited);
        waitResult(0, 8'h0F, lat, en_cnt);
        checkOutput("t1_latency", lat, 9);
        checkOutput("t1_en_cnt", en_cnt, 8);

        $display("[TB] signed vs unsigned, LT and GE");
        a = '0; b = '0;
        a[DW-1:0] = 32'hFFFF_FFFF;
        b[DW-1:0] = 32'd1;
        applyStimulus(2'd0, 1, 0, 4'd1, 1, a, b, 32'd0, 8'h00, 8'h00, waited);
        waitResult(0, 8'h01, lat, en_cnt);
        checkOutput("t2_latency", lat, 2);
        applyStimulus(2'd0, 0, 0, 4'd1, 1, a, b, 32'd0, 8'h00, 8'h00, waited);
        waitResult(0, 8'h00, lat, en_cnt);
        applyStimulus(2'd3, 1, 0, 4'd1, 1, a, b, 32'd0, 8'h00, 8'h00, waited);
        waitResult(0, 8'h00, lat, en_cnt);
        applyStimulus(2'd3, 0, 0, 4'd1, 1, a, b, 32'd0, 8'h00, 8'h00, waited);
        waitResult(0, 8'h01, lat, en_cnt);

        $display("[TB] masked all-true");
        applyStimulus(2'd0, 0, 0, 4'd8, 0, all_lo, all_hi, 32'd0, 8'hAA, 8'h00, waited);
        waitResult(0, 8'hAA, lat, en_cnt);
        checkOutput("t3_en_cnt", en_cnt, 4);

        $display("[TB] vl=0 and tail");
        applyStimulus(2'd0, 0, 0, 4'd0, 1, all_lo, all_hi, 32'd0, 8'h00, 8'h5C, waited);
        waitResult(0, 8'h5C, lat, en_cnt);
        checkOutput("t4_latency", lat, 1);
        checkOutput("t4_en_cnt", en_cnt, 0);
        applyStimulus(2'd0, 0, 0, 4'd3, 1, all_lo, all_hi, 32'd0, 8'h00, 8'hF0, waited);
        waitResult(0, 8'hF7, lat, en_cnt);
        checkOutput("t5_latency", lat, 4);

        $display("[TB] result back-pressure and follow-on accept");
        for (int k = 0; k < NE; k++) a[k*DW +: DW] = DW'(k);
        applyStimulus(2'd0, 0, 1, 4'd8, 1, a, zero, 32'd4, 8'h00, 8'h00, waited);
        waitResult(5, 8'h0F, lat, en_cnt);
        applyStimulus(2'd0, 0, 0, 4'd3, 1, all_lo, all_hi, 32'd0, 8'h00, 8'hF0, waited);
        checkOutput("t6_accept_wait", waited, 1);
        waitResult(0, 8'hF7, lat, en_cnt);

        $display("[TB] kill at element 3");
        applyStimulus(2'd0, 0, 0, 4'd8, 1, all_lo, all_hi, 32'd0, 8'h00, 8'h00, waited);
        repeat (3) @(posedge clk);
        #1 bus.kill_i = 1'b1;
        @(posedge clk);
        #1 bus.kill_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t7_busy", bus.busy_o, 0);
            checkOutput("t7_res_valid", bus.res_valid_o, 0);
            checkOutput("t7_req_ready", bus.req_ready_o, 1);
        end
        @(posedge clk);
        #1;

        $display("[TB] kill while idle is ignored");
        bus.kill_i = 1'b1;
        applyStimulus(2'd0, 0, 0, 4'd3, 1, all_lo, all_hi, 32'd0, 8'h00, 8'hF0, waited);
        bus.kill_i = 1'b0;
        waitResult(0, 8'hF7, lat, en_cnt);

        $display("[TB] reset mid-run");
        applyStimulus(2'd0, 0, 0, 4'd8, 1, all_lo, all_hi, 32'd0, 8'h00, 8'h00, waited);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t9_req_ready", bus.req_ready_o, 1);
        checkOutput("t9_busy", bus.busy_o, 0);
        checkOutput("t9_cmp_en", bus.cmp_en_o, 0);
        checkOutput("t9_res_mask", bus.res_mask_o, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(2'd0, 0, 0, 4'd3, 1, all_lo, all_hi, 32'd0, 8'h00, 8'hF0, waited);
        waitResult(0, 8'hF7, lat, en_cnt);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 80; t++) begin
            op     = 2'($urandom_range(0, 3));
            tc     = 1'($urandom_range(0, 1));
            vx     = 1'($urandom_range(0, 1));
            vl     = 4'($urandom_range(0, 15));
            vm     = 1'($urandom_range(0, 1));
            scalar = rand_elem();
            mask   = 8'($urandom);
            old    = 8'($urandom);
            for (int k = 0; k < NE; k++) begin
                a[k*DW +: DW] = rand_elem();
                b[k*DW +: DW] = rand_elem();
            end
            exp = model_mask(a, b, scalar, op, tc, vx, vl, vm, mask, old);
            vle = clamp_vl(vl);
            applyStimulus(op, tc, vx, vl, vm, a, b, scalar, mask, old, waited);
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, vle + 1);
                repeat (r) @(posedge clk);
                #1 bus.kill_i = 1'b1;
                @(posedge clk);
                #1 bus.kill_i = 1'b0;
                @(negedge clk);
                checkOutput("rand_kill_busy", bus.busy_o, 0);
                @(posedge clk);
                #1;
            end else begin
                waitResult($urandom_range(0, 3), exp, lat, en_cnt);
                checkOutput("rand_latency", lat, vle + 1);
            end
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
